decode_stage: RTL and testbench

//  Registered RV32I/RV64I decode stage between fetch and execute. Decodes one instruction
//  per accepted beat into a control packet: immediate, ALU op, register fields, memory/jump

---
 rtl/core_pkg.sv | 62 ++++++
 rtl/decode_logic.sv | 172 +++++++++++++++++
 rtl/decode_stage.sv | 114 +++++++++++
 tb/tb_decode_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types: opcodes, ALU/jump/env encodings, and
// the decode control packet passed from decode to execute.
package core_pkg;

  localparam int Ilen = 32;

  typedef enum logic [1:0] {
    AluAdd    = 2'b00,
    AluFunct  = 2'b01,
    AluBranch = 2'b10
  } aluop_e;

  typedef enum logic [1:0] {
    JumpNone = 2'b00,
    JumpJal  = 2'b01,
    JumpJalr = 2'b10
  } jump_type_e;

  typedef enum logic [1:0] {
    EnvNone  = 2'b00,
    EnvCall  = 2'b01,
    EnvBreak = 2'b10
  } env_e;

  typedef enum logic [6:0] {
    OpLoad    = 7'b0000011,
    OpAluImm  = 7'b0010011,
    OpAuipc   = 7'b0010111,
    OpAluImmW = 7'b0011011,
    OpStore   = 7'b0100011,
    OpAlu     = 7'b0110011,
    OpLui     = 7'b0110111,
    OpAluW    = 7'b0111011,
    OpBranch  = 7'b1100011,
    OpJalr    = 7'b1100111,
    OpJal     = 7'b1101111,
    OpEnv     = 7'b1110011
  } opcode_e;

  // Xlen-independent part of the packet; the Xlen-wide
  // immediate and PC ride alongside it in the stage.
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] funct3;
    aluop_e     aluop;
    logic       alu_use_imm;
    logic       reg_wb;
    logic       reg_lui;
    logic       is_auipc;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    jump_type_e jump;
    logic       word;
    env_e       env;
    logic       illegal;
  } decode_pkt_t;

endpackage

// File: rtl/decode_logic.sv
// Combinational RV32I/RV64I decoder: instr -> control packet
// plus sign-extended immediate (Xlen wide).
module decode_logic
  import core_pkg::*;
#(
  parameter int Xlen = 32
) (
  input  logic [Ilen-1:0] instr,
  output decode_pkt_t     pkt,
  output logic [Xlen-1:0] imm
);

  localparam bit Rv64 = (Xlen == 64);

  logic [6:0] op;
  logic [6:0] f7;
  logic [2:0] f3;
  logic       ill;
  logic       sh_ok;
  logic       alt_ok;

  logic signed [31:0] imm_i;
  logic signed [31:0] imm_s;
  logic signed [31:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [31:0] imm_j;

  assign op = instr[6:0];
  assign f7 = instr[31:25];
  assign f3 = instr[14:12];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25],
                  instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31],
                  instr[19:12], instr[20],
                  instr[30:21], 1'b0};

  // RV64 shifts carry a 6-bit shamt, so only [31:26] is funct
  always_comb begin
    sh_ok  = 1'b0;
    alt_ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
    if (f3 == 3'b001) begin
      sh_ok = Rv64 ? (instr[31:26] == 6'b000000)
                   : (f7 == 7'b0000000);
    end else if (f3 == 3'b101) begin
      sh_ok = Rv64 ? ((instr[31:26] == 6'b000000) ||
                      (instr[31:26] == 6'b010000))
                   : alt_ok;
    end else begin
      sh_ok = 1'b1;
    end
  end

  always_comb begin
    pkt        = '0;
    pkt.rs1    = instr[19:15];
    pkt.rs2    = instr[24:20];
    pkt.rd     = instr[11:7];
    pkt.funct3 = f3;
    pkt.aluop  = AluAdd;
    pkt.jump   = JumpNone;
    pkt.env    = EnvNone;
    imm        = '0;
    ill        = 1'b0;
    unique case (1'b1)
      (op == OpAlu): begin
        pkt.reg_wb = 1'b1;
        pkt.aluop  = AluFunct;
        ill = !((f7 == 7'b0000000) ||
                (f7 == 7'b0100000 &&
                 (f3 == 3'b000 || f3 == 3'b101)));
      end
      (op == OpAluImm): begin
        pkt.reg_wb      = 1'b1;
        pkt.aluop       = AluFunct;
        pkt.alu_use_imm = 1'b1;
        imm = Xlen'(imm_i);
        ill = !sh_ok;
      end
      (op == OpAluImmW): begin
        pkt.reg_wb      = 1'b1;
        pkt.aluop       = AluFunct;
        pkt.alu_use_imm = 1'b1;
        pkt.word        = Rv64;
        imm = Xlen'(imm_i);
        if (f3 == 3'b000) ill = 1'b0;
        else if (f3 == 3'b001) ill = (f7 != 7'b0);
        else if (f3 == 3'b101) ill = !alt_ok;
        else ill = 1'b1;
        if (!Rv64) ill = 1'b1;
      end
      (op == OpAluW): begin
        pkt.reg_wb = 1'b1;
        pkt.aluop  = AluFunct;
        pkt.word   = Rv64;
        if (f3 == 3'b000 || f3 == 3'b101) ill = !alt_ok;
        else if (f3 == 3'b001) ill = (f7 != 7'b0);
        else ill = 1'b1;
        if (!Rv64) ill = 1'b1;
      end
      (op == OpLoad): begin
        pkt.reg_wb      = 1'b1;
        pkt.mem_read    = 1'b1;
        pkt.mem_to_reg  = 1'b1;
        pkt.alu_use_imm = 1'b1;
        imm = Xlen'(imm_i);
        ill = (f3 == 3'b111) ||
              (!Rv64 && (f3 == 3'b011 || f3 == 3'b110));
      end
      (op == OpStore): begin
        pkt.mem_write   = 1'b1;
        pkt.alu_use_imm = 1'b1;
        imm = Xlen'(imm_s);
        ill = f3[2] || (!Rv64 && f3 == 3'b011);
      end
      (op == OpBranch): begin
        pkt.branch = 1'b1;
        pkt.aluop  = AluBranch;
        imm = Xlen'(imm_b);
        ill = (f3 == 3'b010) || (f3 == 3'b011);
      end
      (op == OpJal): begin
        pkt.reg_wb = 1'b1;
        pkt.jump   = JumpJal;
        imm = Xlen'(imm_j);
      end
      (op == OpJalr): begin
        pkt.reg_wb      = 1'b1;
        pkt.alu_use_imm = 1'b1;
        pkt.jump        = JumpJalr;
        imm = Xlen'(imm_i);
        ill = (f3 != 3'b000);
      end
      (op == OpLui): begin
        pkt.reg_wb  = 1'b1;
        pkt.reg_lui = 1'b1;
        imm = Xlen'(imm_u);
      end
      (op == OpAuipc): begin
        pkt.reg_wb      = 1'b1;
        pkt.is_auipc    = 1'b1;
        pkt.alu_use_imm = 1'b1;
        imm = Xlen'(imm_u);
      end
      (op == OpEnv): begin
        if (instr == 32'h0000_0073) pkt.env = EnvCall;
        else if (instr == 32'h0010_0073) pkt.env = EnvBreak;
        else ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    // an illegal packet still flows but must have no effects
    if (ill) begin
      pkt.reg_wb     = 1'b0;
      pkt.reg_lui    = 1'b0;
      pkt.is_auipc   = 1'b0;
      pkt.branch     = 1'b0;
      pkt.mem_read   = 1'b0;
      pkt.mem_write  = 1'b0;
      pkt.mem_to_reg = 1'b0;
      pkt.jump       = JumpNone;
      pkt.word       = 1'b0;
      pkt.env        = EnvNone;
    end
    pkt.illegal = ill;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decode_logic feeding an output
// register plus a skid entry; valid/ready on both sides, flush.
module decode_stage
  import core_pkg::*;
#(
  parameter int Xlen = 32,
  parameter int Ilen = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [Ilen-1:0] instr_i,
  input  logic [Xlen-1:0] pc_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [Xlen-1:0] pc_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [2:0]      funct3_o,
  output logic [Xlen-1:0] imm_o,
  output aluop_e          aluop_o,
  output logic            alu_use_imm_o,
  output logic            reg_wb_o,
  output logic            reg_lui_o,
  output logic            is_auipc_o,
  output logic            branch_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            mem_to_reg_o,
  output jump_type_e      jump_o,
  output logic            word_o,
  output logic [1:0]      env_o,
  output logic            illegal_o
);

  typedef struct packed {
    logic [Xlen-1:0] pc;
    logic [Xlen-1:0] imm;
    decode_pkt_t     pkt;
  } entry_t;

  entry_t in_e;
  entry_t out_q;
  entry_t skid_q;
  logic   out_v;
  logic   skid_v;
  logic   acc;
  logic   drain;

  decode_logic #(.Xlen(Xlen)) u_dec (
    .instr (instr_i),
    .pkt   (in_e.pkt),
    .imm   (in_e.imm)
  );

  assign in_e.pc = pc_i;

  // ready depends only on skid state: no path from ready_i
  assign ready_o = !skid_v;
  assign acc     = valid_i && ready_o;
  assign drain   = !out_v || ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
    end else if (flush_i) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (drain) begin
      // acc implies skid empty, so the two never collide
      if (skid_v) begin
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= 1'b0;
      end else if (acc) begin
        out_q <= in_e;
        out_v <= 1'b1;
      end else begin
        out_v <= 1'b0;
      end
    end else if (acc) begin
      skid_q <= in_e;
      skid_v <= 1'b1;
    end
  end

  assign valid_o       = out_v;
  assign pc_o          = out_q.pc;
  assign imm_o         = out_q.imm;
  assign rs1_o         = out_q.pkt.rs1;
  assign rs2_o         = out_q.pkt.rs2;
  assign rd_o          = out_q.pkt.rd;
  assign funct3_o      = out_q.pkt.funct3;
  assign aluop_o       = out_q.pkt.aluop;
  assign alu_use_imm_o = out_q.pkt.alu_use_imm;
  assign reg_wb_o      = out_q.pkt.reg_wb;
  assign reg_lui_o     = out_q.pkt.reg_lui;
  assign is_auipc_o    = out_q.pkt.is_auipc;
  assign branch_o      = out_q.pkt.branch;
  assign mem_read_o    = out_q.pkt.mem_read;
  assign mem_write_o   = out_q.pkt.mem_write;
  assign mem_to_reg_o  = out_q.pkt.mem_to_reg;
  assign jump_o        = out_q.pkt.jump;
  assign word_o        = out_q.pkt.word;
  assign env_o         = out_q.pkt.env;
  assign illegal_o     = out_q.pkt.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one Xlen=32 and one Xlen=64
// instance share stimulus; checks by immediate assertions.
module tb_decode_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] instr;
  logic [63:0] pc;

  logic        rdy_a, vld_a, aui_a, wb_a, lui_a, ia_a;
  logic        br_a, mr_a, mw_a, m2r_a, w_a, ill_a;
  logic [31:0] pc_a, imm_a;
  logic [4:0]  rs1_a, rs2_a, rd_a;
  logic [2:0]  f3_a;
  aluop_e      alu_a;
  jump_type_e  j_a;
  logic [1:0]  env_a;

  logic        rdy_b, vld_b, aui_b, wb_b, lui_b, ia_b;
  logic        br_b, mr_b, mw_b, m2r_b, w_b, ill_b;
  logic [63:0] pc_b, imm_b;
  logic [4:0]  rs1_b, rs2_b, rd_b;
  logic [2:0]  f3_b;
  aluop_e      alu_b;
  jump_type_e  j_b;
  logic [1:0]  env_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_stage #(.Xlen(32)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .valid_i(valid_in), .ready_o(rdy_a), .instr_i(instr),
    .pc_i(pc[31:0]), .valid_o(vld_a), .ready_i(ready_in),
    .pc_o(pc_a), .rs1_o(rs1_a), .rs2_o(rs2_a), .rd_o(rd_a),
    .funct3_o(f3_a), .imm_o(imm_a), .aluop_o(alu_a),
    .alu_use_imm_o(aui_a), .reg_wb_o(wb_a),
    .reg_lui_o(lui_a), .is_auipc_o(ia_a), .branch_o(br_a),
    .mem_read_o(mr_a), .mem_write_o(mw_a),
    .mem_to_reg_o(m2r_a), .jump_o(j_a), .word_o(w_a),
    .env_o(env_a), .illegal_o(ill_a)
  );

  decode_stage #(.Xlen(64)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .valid_i(valid_in), .ready_o(rdy_b), .instr_i(instr),
    .pc_i(pc), .valid_o(vld_b), .ready_i(ready_in),
    .pc_o(pc_b), .rs1_o(rs1_b), .rs2_o(rs2_b), .rd_o(rd_b),
    .funct3_o(f3_b), .imm_o(imm_b), .aluop_o(alu_b),
    .alu_use_imm_o(aui_b), .reg_wb_o(wb_b),
    .reg_lui_o(lui_b), .is_auipc_o(ia_b), .branch_o(br_b),
    .mem_read_o(mr_b), .mem_write_o(mw_b),
    .mem_to_reg_o(m2r_b), .jump_o(j_b), .word_o(w_b),
    .env_o(env_b), .illegal_o(ill_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    valid_in = 1'b1;
    instr    = w;
    step();
    valid_in = 1'b0;
  endtask

  function automatic logic [31:0] mk(input int n);
    return (32'(n) << 20) | (32'(n) << 7) | 32'h13;
  endfunction

  initial begin
    int nacc;
    int ndel;
    bit saw_low;
    bit acc;
    bit del;
    bit hold;
    logic [4:0] rd_s;

    rst_n    = 1'b0;
    flush    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    instr    = '0;
    pc       = '0;
    #12;
    chk("rst_valid", 64'(vld_a), 64'd0);
    chk("rst_ready", 64'(rdy_a), 64'd1);
    chk("rst_imm", imm_b, 64'd0);
    chk("rst_aluop", 64'(alu_a), 64'(AluAdd));
    chk("rst_jump", 64'(j_a), 64'(JumpNone));
    chk("rst_wb", 64'(wb_a), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // 1: addi x1,x0,-1
    ready_in = 1'b1;
    pc = 64'h100;
    send(32'hFFF0_0093);
    chk("t1_valid", 64'(vld_a), 64'd1);
    chk("t1_imm32", 64'(imm_a), 64'hFFFF_FFFF);
    chk("t1_imm64", imm_b, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t1_rd", 64'(rd_a), 64'd1);
    chk("t1_aluop", 64'(alu_a), 64'(AluFunct));
    chk("t1_useimm", 64'(aui_a), 64'd1);
    chk("t1_wb", 64'(wb_a), 64'd1);
    chk("t1_pc", 64'(pc_a), 64'h100);
    chk("t1_ill", 64'(ill_a), 64'd0);
    step();
    chk("t1_drain", 64'(vld_a), 64'd0);

    // 2: 4-beat stream with ready_i low for 3 cycles
    nacc = 0;
    ndel = 0;
    saw_low = 1'b0;
    for (int cyc = 0; cyc < 30 && ndel < 4; cyc++) begin
      valid_in = (nacc < 4);
      instr    = mk(nacc + 1);
      ready_in = !(cyc >= 2 && cyc <= 4);
      acc  = valid_in && rdy_a;
      del  = vld_a && ready_in;
      hold = vld_a && !ready_in;
      rd_s = rd_a;
      if (!rdy_a) saw_low = 1'b1;
      step();
      if (acc) nacc++;
      if (del) begin
        chk("t2_order", 64'(rd_s), 64'(ndel + 1));
        ndel++;
      end
      if (hold) chk("t2_stable", 64'(rd_a), 64'(rd_s));
    end
    valid_in = 1'b0;
    chk("t2_count", 64'(ndel), 64'd4);
    chk("t2_ready_fell", 64'(saw_low), 64'd1);
    chk("t2_no_dup", 64'(vld_a), 64'd0);

    // 3: flush with skid full, then flush with ready_o high
    ready_in = 1'b0;
    send(mk(10));
    chk("t3_out", 64'(rd_a), 64'd10);
    send(mk(11));
    chk("t3_skid_full", 64'(rdy_a), 64'd0);
    flush    = 1'b1;
    valid_in = 1'b1;
    instr    = mk(12);
    step();
    chk("t3_flush_valid", 64'(vld_a), 64'd0);
    chk("t3_flush_ready", 64'(rdy_a), 64'd1);
    instr = mk(13);
    step();
    chk("t3_flush_drop", 64'(vld_b), 64'd0);
    flush    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    step();
    chk("t3_never", 64'(vld_a), 64'd0);

    // 4: illegal zero word, ecall, ebreak, bad SYSTEM
    send(32'h0000_0000);
    chk("t4_zero_ill", 64'(ill_a), 64'd1);
    chk("t4_zero_wb", 64'(wb_a), 64'd0);
    chk("t4_zero_valid", 64'(vld_a), 64'd1);
    send(32'h0000_0073);
    chk("t4_ecall", 64'(env_a), 64'd1);
    chk("t4_ecall_ill", 64'(ill_a), 64'd0);
    send(32'h0010_0073);
    chk("t4_ebreak", 64'(env_b), 64'd2);
    send(32'h1000_0073);
    chk("t4_sys_ill", 64'(ill_a), 64'd1);
    chk("t4_sys_env", 64'(env_a), 64'd0);

    // other formats: lw, sw, beq, lui, jal, slli shamt 32
    send(32'hFFC0_A183);
    chk("ld_imm", 64'(imm_a), 64'hFFFF_FFFC);
    chk("ld_flags", {61'd0, mr_a, m2r_a, wb_a}, 64'h7);
    send(32'h0020_A423);
    chk("st_imm", 64'(imm_a), 64'd8);
    chk("st_flags", {62'd0, mw_a, wb_a}, 64'h2);
    send(32'hFE20_8CE3);
    chk("br_imm", 64'(imm_a), 64'hFFFF_FFF8);
    chk("br_alu", 64'(alu_a), 64'(AluBranch));
    chk("br_flag", 64'(br_a), 64'd1);
    send(32'h8000_02B7);
    chk("lui_imm32", 64'(imm_a), 64'h8000_0000);
    chk("lui_imm64", imm_b, 64'hFFFF_FFFF_8000_0000);
    chk("lui_flag", 64'(lui_a), 64'd1);
    send(32'h0080_00EF);
    chk("jal_imm", 64'(imm_a), 64'd8);
    chk("jal_jump", 64'(j_a), 64'(JumpJal));
    send(32'h0200_9093);
    chk("sh32_ill", 64'(ill_a), 64'd1);
    chk("sh64_ok", 64'(ill_b), 64'd0);

    // 5: addiw x1,x1,-1
    send(32'hFFF0_809B);
    chk("w64_word", 64'(w_b), 64'd1);
    chk("w64_imm", imm_b, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("w64_ill", 64'(ill_b), 64'd0);
    chk("w32_ill", 64'(ill_a), 64'd1);
    chk("w32_word", 64'(w_a), 64'd0);
    chk("w32_wb", 64'(wb_a), 64'd0);

    // 6: async reset mid-stream
    ready_in = 1'b0;
    send(mk(20));
    send(mk(21));
    chk("t6_pre", 64'(vld_a), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(vld_a), 64'd0);
    chk("t6_async_ready", 64'(rdy_b), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ready_in = 1'b1;
    step();
    chk("t6_ready", 64'(rdy_a), 64'd1);
    chk("t6_empty", 64'(vld_a), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
